// File: rtl/apbocp_mfifo.sv
// rtl/apbocp_mfifo.sv - multi-channel OCP-to-APB byte FIFO bridge
//
// Purpose: an OCP master pushes entries into one of NCHAN FIFOs, selected by
// address. An APB master pops entries, reads fill levels and status, and
// clears sticky overflow flags.
// Optional feature macro: APBOCP_MFIFO_IRQ_EN enables the THRESH and IRQ_EN
// registers and the irq output. Without it, irq is 0 and those registers
// read as 0.
//
// Ports:
//   clk, nrst               clock, asynchronous active-low reset
//   apb_paddr/psel/penable  APB request; every access has one wait state
//   apb_pwrite/pwdata       APB write direction and data
//   apb_prdata/pready       APB response (registered)
//   ocp_maddr/mcmd/mdata    OCP request (mcmd: 0 idle, 1 write, 2 read)
//   ocp_mbyteen             OCP byte enables; bit 0 gates the push
//   ocp_scmdaccept          always 1
//   ocp_sdata/sresp         OCP response, valid for one cycle after a command
//   irq                     level interrupt (optional feature)
module apbocp_mfifo #(
  parameter int NCHAN           = 4,
  parameter int FIFO_DEPTH      = 256,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int OCP_ADDR_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  input  logic                      apb_psel,
  input  logic                      apb_penable,
  input  logic                      apb_pwrite,
  input  logic [DATA_WIDTH-1:0]     apb_pwdata,
  output logic [DATA_WIDTH-1:0]     apb_prdata,
  output logic                      apb_pready,
  input  logic [OCP_ADDR_WIDTH-1:0] ocp_maddr,
  input  logic [2:0]                ocp_mcmd,
  input  logic [DATA_WIDTH-1:0]     ocp_mdata,
  input  logic [DATA_WIDTH/8-1:0]   ocp_mbyteen,
  output logic                      ocp_scmdaccept,
  output logic [DATA_WIDTH-1:0]     ocp_sdata,
  output logic [1:0]                ocp_sresp,
  output logic                      irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int FW = FIFO_DATA_WIDTH;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic {S_IDLE, S_RESP} apb_state_t;

  logic [FW-1:0]         mem    [NCHAN][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr [NCHAN];
  logic [PW-1:0]         rd_ptr [NCHAN];
  logic [PW-1:0]         level  [NCHAN];
  logic [NCHAN-1:0]      not_empty, full, push, pop, ovf, ovf_set, ovf_clr;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] thresh_rd, irq_en_rd;
  apb_state_t            apb_state;

  // APB address decode: [7:6] selects DATA/LEVEL/register region, [5:2] the slot
  logic          apb_access, addr_ok, a_ch_ok, reg_wr;
  logic [1:0]    a_region;
  logic [3:0]    a_idx;
  logic [CW-1:0] a_ch;
  logic [FW-1:0] rd_entry;

  assign apb_access = (apb_state == S_IDLE) && apb_psel && apb_penable;
  assign addr_ok    = (apb_paddr[APB_ADDR_WIDTH-1:8] == '0);
  assign a_region   = apb_paddr[7:6];
  assign a_idx      = apb_paddr[5:2];
  assign a_ch_ok    = addr_ok && ({28'd0, a_idx} < 32'(NCHAN));
  assign a_ch       = a_idx[CW-1:0];
  assign rd_entry   = mem[a_ch][rd_ptr[a_ch][AW-1:0]];
  assign reg_wr     = apb_access && apb_pwrite && addr_ok && (a_region == 2'd2);
  assign ovf_clr    = (reg_wr && a_idx == 4'd1) ? apb_pwdata[NCHAN-1:0] : '0;

  // OCP decode
  logic          ocp_wr_hit;
  logic [CW-1:0] o_ch;

  assign ocp_wr_hit     = (ocp_mcmd == 3'd1) && (ocp_maddr <= OCP_ADDR_WIDTH'(4 * NCHAN - 4));
  assign o_ch           = ocp_maddr[2 +: CW];
  assign ocp_scmdaccept = 1'b1;

  // Input bits that carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{apb_pwdata, ocp_mdata, ocp_mbyteen, apb_paddr[1:0]};

  always_comb begin
    status = '0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      level[ch]     = wr_ptr[ch] - rd_ptr[ch];
      not_empty[ch] = (level[ch] != '0);
      full[ch]      = (level[ch] == PW'(FIFO_DEPTH));
      status[ch]      = not_empty[ch];
      status[16 + ch] = full[ch];
    end
  end

  // Push and pop are both judged on the pre-cycle full/empty state, so a
  // same-cycle pop never rescues a push to a full FIFO and vice versa.
  always_comb begin
    for (int ch = 0; ch < NCHAN; ch++) begin
      pop[ch]     = apb_access && !apb_pwrite && a_ch_ok && (a_region == 2'd0)
                    && (a_ch == CW'(ch)) && not_empty[ch];
      push[ch]    = ocp_wr_hit && ocp_mbyteen[0] && (o_ch == CW'(ch)) && !full[ch];
      ovf_set[ch] = ocp_wr_hit && ocp_mbyteen[0] && (o_ch == CW'(ch)) && full[ch];
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NCHAN; ch++) begin
      if (push[ch]) mem[ch][wr_ptr[ch][AW-1:0]] <= ocp_mdata[FW-1:0];
    end
  end

  // Set beats W1C clear on the same bit
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int ch = 0; ch < NCHAN; ch++) begin
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int ch = 0; ch < NCHAN; ch++) begin
        if (push[ch]) wr_ptr[ch] <= wr_ptr[ch] + 1'b1;
        if (pop[ch])  rd_ptr[ch] <= rd_ptr[ch] + 1'b1;
      end
      ovf <= (ovf & ~ovf_clr) | ovf_set;
    end
  end

`ifdef APBOCP_MFIFO_IRQ_EN
  logic [12:0]      thresh;
  logic [NCHAN-1:0] irq_en;
  logic             irq_next;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      thresh <= '0;
      irq_en <= '0;
    end else begin
      if (reg_wr && a_idx == 4'd2) thresh <= apb_pwdata[12:0];
      if (reg_wr && a_idx == 4'd3) irq_en <= apb_pwdata[NCHAN-1:0];
    end
  end

  always_comb begin
    irq_next = 1'b0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      if (irq_en[ch] && (ovf[ch] || (32'(level[ch]) > 32'(thresh)))) irq_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) irq <= 1'b0;
    else       irq <= irq_next;
  end

  assign thresh_rd = DATA_WIDTH'(thresh);
  assign irq_en_rd = DATA_WIDTH'(irq_en);
`else
  assign irq       = 1'b0;
  assign thresh_rd = '0;
  assign irq_en_rd = '0;
`endif

  // APB read mux; unmapped or out-of-range slots read all ones
  always_comb begin
    rdata = '1;
    if (addr_ok) begin
      case (a_region)
        2'd0: if (a_ch_ok) begin
          rdata     = '0;
          rdata[30] = full[a_ch];
          if (not_empty[a_ch]) rdata[FW-1:0] = rd_entry;
          else                 rdata[31]     = 1'b1;
        end
        2'd1: if (a_ch_ok) rdata = DATA_WIDTH'(level[a_ch]);
        2'd2: begin
          case (a_idx)
            4'd0:    rdata = status;
            4'd1:    rdata = DATA_WIDTH'(ovf);
            4'd2:    rdata = thresh_rd;
            4'd3:    rdata = irq_en_rd;
            default: rdata = '1;
          endcase
        end
        default: rdata = '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      apb_state  <= S_IDLE;
      apb_pready <= 1'b0;
      apb_prdata <= '0;
    end else begin
      case (apb_state)
        S_IDLE: if (apb_psel && apb_penable) begin
          apb_state  <= S_RESP;
          apb_pready <= 1'b1;
          apb_prdata <= apb_pwrite ? '0 : rdata;
        end
        S_RESP: begin
          apb_state  <= S_IDLE;
          apb_pready <= 1'b0;
        end
        default: apb_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ocp_sresp <= RESP_NULL;
      ocp_sdata <= '0;
    end else begin
      ocp_sresp <= RESP_NULL;
      ocp_sdata <= '0;
      if (ocp_wr_hit) begin
        ocp_sresp <= (ocp_mbyteen[0] && full[o_ch]) ? RESP_FAIL : RESP_DVA;
      end else if (ocp_mcmd == 3'd2 && ocp_maddr == OCP_ADDR_WIDTH'(32'h80)) begin
        ocp_sresp <= RESP_DVA;
        ocp_sdata <= status;
      end else if (ocp_mcmd != 3'd0) begin
        ocp_sresp <= RESP_ERR;
      end
    end
  end

endmodule

// File: tb/tb_apbocp_mfifo.sv
// tb/tb_apbocp_mfifo.sv - self-checking bench for apbocp_mfifo
module tb_apbocp_mfifo;
  localparam int NCHAN = 4;
  localparam int DEPTH = 16;
  localparam int FW    = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] apb_paddr = '0;
  logic        apb_psel = 1'b0, apb_penable = 1'b0, apb_pwrite = 1'b0;
  logic [31:0] apb_pwdata = '0;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic [31:0] ocp_maddr = '0;
  logic [2:0]  ocp_mcmd = '0;
  logic [31:0] ocp_mdata = '0;
  logic [3:0]  ocp_mbyteen = '0;
  logic        ocp_scmdaccept;
  logic [31:0] ocp_sdata;
  logic [1:0]  ocp_sresp;
  logic        irq;

  apbocp_mfifo #(.NCHAN(NCHAN), .FIFO_DEPTH(DEPTH), .FIFO_DATA_WIDTH(FW)) dut (
    .clk(clk), .nrst(nrst),
    .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready),
    .ocp_maddr(ocp_maddr), .ocp_mcmd(ocp_mcmd), .ocp_mdata(ocp_mdata),
    .ocp_mbyteen(ocp_mbyteen), .ocp_scmdaccept(ocp_scmdaccept),
    .ocp_sdata(ocp_sdata), .ocp_sresp(ocp_sresp), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [FW-1:0]    mq [NCHAN][$];
  logic [NCHAN-1:0] m_ovf = '0;
  logic [12:0]      m_thresh = '0;
  logic [NCHAN-1:0] m_irq_en = '0;
  logic             m_busy = 1'b0;
  logic             exp_pready = 1'b0, exp_rd = 1'b0, exp_irq = 1'b0;
  logic [31:0]      exp_prdata = '0, exp_sdata = '0;
  logic [1:0]       exp_sresp = '0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    for (int c = 0; c < NCHAN; c++) begin
      s[c]      = (mq[c].size() != 0);
      s[16 + c] = (mq[c].size() == DEPTH);
    end
    return s;
  endfunction

  task automatic model_step();
    int pre [NCHAN];
    int w, c, pop_ch, push_ch;
    logic [NCHAN-1:0] set_v, clr_v;
    logic [FW-1:0] push_val;
    logic [31:0] st, val;
    if (!nrst) begin
      for (int k = 0; k < NCHAN; k++) mq[k].delete();
      m_ovf = '0; m_thresh = '0; m_irq_en = '0; m_busy = 1'b0;
      exp_pready = 1'b0; exp_rd = 1'b0; exp_irq = 1'b0;
      exp_prdata = '0; exp_sdata = '0; exp_sresp = 2'd0;
      return;
    end
    st = m_status();
    for (int k = 0; k < NCHAN; k++) pre[k] = mq[k].size();
    exp_irq = 1'b0;
`ifdef APBOCP_MFIFO_IRQ_EN
    for (int k = 0; k < NCHAN; k++)
      if (m_irq_en[k] && (m_ovf[k] || pre[k] > int'(m_thresh))) exp_irq = 1'b1;
`endif
    pop_ch = -1; push_ch = -1; set_v = '0; clr_v = '0; push_val = '0;

    if (m_busy) begin
      m_busy = 1'b0;
      exp_pready = 1'b0;
    end else if (apb_psel && apb_penable) begin
      m_busy = 1'b1;
      exp_pready = 1'b1;
      exp_rd = !apb_pwrite;
      w = int'(apb_paddr[7:2]);
      val = 32'hFFFF_FFFF;
      if (apb_paddr[31:8] == 24'd0) begin
        if (w < NCHAN) begin
          if (pre[w] == 0) val = 32'h8000_0000;
          else begin
            val = 32'(mq[w][0]);
            if (!apb_pwrite) pop_ch = w;
          end
          if (pre[w] == DEPTH) val = val | 32'h4000_0000;
        end else if (w >= 16 && w < 16 + NCHAN) val = 32'(pre[w - 16]);
        else if (w == 32) val = st;
        else if (w == 33) val = 32'(m_ovf);
`ifdef APBOCP_MFIFO_IRQ_EN
        else if (w == 34) val = 32'(m_thresh);
        else if (w == 35) val = 32'(m_irq_en);
`else
        else if (w == 34 || w == 35) val = 32'd0;
`endif
        if (apb_pwrite) begin
          if (w == 33) clr_v = apb_pwdata[NCHAN-1:0];
`ifdef APBOCP_MFIFO_IRQ_EN
          if (w == 34) m_thresh = apb_pwdata[12:0];
          if (w == 35) m_irq_en = apb_pwdata[NCHAN-1:0];
`endif
        end
      end
      exp_prdata = apb_pwrite ? 32'd0 : val;
    end

    exp_sresp = 2'd0;
    exp_sdata = '0;
    if (ocp_mcmd == 3'd1 && ocp_maddr <= 32'(4 * NCHAN - 4)) begin
      c = int'(ocp_maddr >> 2);
      if (!ocp_mbyteen[0]) exp_sresp = 2'd1;
      else if (pre[c] == DEPTH) begin
        exp_sresp = 2'd2;
        set_v[c] = 1'b1;
      end else begin
        exp_sresp = 2'd1;
        push_ch = c;
        push_val = ocp_mdata[FW-1:0];
      end
    end else if (ocp_mcmd == 3'd2 && ocp_maddr == 32'h80) begin
      exp_sresp = 2'd1;
      exp_sdata = st;
    end else if (ocp_mcmd != 3'd0) exp_sresp = 2'd3;

    if (pop_ch >= 0) void'(mq[pop_ch].pop_front());
    if (push_ch >= 0) mq[push_ch].push_back(push_val);
    m_ovf = (m_ovf & ~clr_v) | set_v;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (nrst) begin
      check("pready", 32'(apb_pready), 32'(exp_pready));
      if (exp_pready && exp_rd) check("prdata", apb_prdata, exp_prdata);
      check("sresp", 32'(ocp_sresp), 32'(exp_sresp));
      check("sdata", ocp_sdata, exp_sdata);
      check("irq", 32'(irq), 32'(exp_irq));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int cyc);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr;
    apb_paddr = addr; apb_pwdata = wdata;
    @(negedge clk);
    apb_penable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!apb_pready && cyc < 8);
    if (!apb_pready) check("apb_timeout", 32'(apb_pready), 32'd1);
    rdata = apb_prdata;
    apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
  endtask

  task automatic apb_rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int cyc;
    apb_xfer(1'b0, addr, 32'd0, d, cyc);
    check(name, d, exp);
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    int cyc;
    apb_xfer(1'b1, addr, wdata, d, cyc);
  endtask

  task automatic ocp_xfer(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output logic [1:0] resp, output logic [31:0] sdata);
    ocp_mcmd = cmd; ocp_maddr = addr; ocp_mdata = data; ocp_mbyteen = be;
    @(negedge clk);
    resp = ocp_sresp;
    sdata = ocp_sdata;
    ocp_mcmd = 3'd0;
  endtask

  logic [31:0] rd, sd;
  logic [1:0]  rsp;
  int          cyc, r, phase, wait_cnt;

  initial begin
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // reset state
    check("sresp_reset", 32'(ocp_sresp), 32'd0);
    check("irq_reset", 32'(irq), 32'd0);
    apb_rd_chk("status_reset", 32'h80, 32'h0000_0000);
    apb_rd_chk("data0_empty", 32'h00, 32'h8000_0000);

    // single push / pop on ch1 with one wait state
    ocp_xfer(3'd1, 32'h04, 32'h0000_1241, 4'hF, rsp, sd);
    check("push_ch1_resp", 32'(rsp), 32'd1);
    apb_rd_chk("level_ch1_1", 32'h44, 32'd1);
    apb_xfer(1'b0, 32'h04, 32'd0, rd, cyc);
    check("data_ch1", rd, 32'h0000_0041);
    check("apb_wait_states", 32'(cyc), 32'd1);
    apb_rd_chk("level_ch1_0", 32'h44, 32'd0);

    // fill ch0, overflow, W1C
    for (int i = 0; i < DEPTH; i++) begin
      ocp_xfer(3'd1, 32'h00, 32'(i), 4'h1, rsp, sd);
      check("fill_ch0_resp", 32'(rsp), 32'd1);
    end
    ocp_xfer(3'd1, 32'h00, 32'hEE, 4'h1, rsp, sd);
    check("ovf_ch0_resp", 32'(rsp), 32'd2);
    apb_rd_chk("status_full", 32'h80, 32'h0001_0001);
    apb_rd_chk("ovf_set", 32'h84, 32'h0000_0001);
    apb_wr(32'h84, 32'h1);
    apb_rd_chk("ovf_clear", 32'h84, 32'h0000_0000);
    ocp_xfer(3'd1, 32'h00, 32'h55, 4'h0, rsp, sd);
    check("be0_clear_resp", 32'(rsp), 32'd1);

    // ch2 at level 3: same-cycle push and pop across pointer wrap
    for (int i = 0; i < 3; i++) ocp_xfer(3'd1, 32'h08, 32'(8'hA0 + i), 4'h1, rsp, sd);
    for (int i = 0; i < 2 * DEPTH + 8; i++) begin
      fork
        apb_xfer(1'b0, 32'h08, 32'd0, rd, cyc);
        begin
          @(negedge clk);
          ocp_xfer(3'd1, 32'h08, 32'(8'(8'hA0 + i + 3)), 4'h1, rsp, sd);
        end
      join
      check("wrap_pop_data", rd, 32'(8'(8'hA0 + i)));
      check("wrap_push_resp", 32'(rsp), 32'd1);
      if (i % 8 == 7) apb_rd_chk("wrap_level", 32'h48, 32'd3);
    end

    // error paths and OCP status read
    ocp_xfer(3'd1, 32'h40, 32'h1, 4'h1, rsp, sd);
    check("ocp_bad_addr", 32'(rsp), 32'd3);
    ocp_xfer(3'd5, 32'h00, 32'h1, 4'h1, rsp, sd);
    check("ocp_bad_cmd", 32'(rsp), 32'd3);
    apb_rd_chk("apb_unmapped", 32'h90, 32'hFFFF_FFFF);
    apb_rd_chk("apb_bad_ch", 32'h10, 32'hFFFF_FFFF);
    apb_rd_chk("apb_high_bits", 32'h180, 32'hFFFF_FFFF);
    ocp_xfer(3'd2, 32'h80, 32'h0, 4'h0, rsp, sd);
    check("ocp_status_resp", 32'(rsp), 32'd1);
    check("ocp_status_data", sd, 32'h0001_0005);

`ifdef APBOCP_MFIFO_IRQ_EN
    apb_wr(32'h88, 32'd2);
    apb_wr(32'h8C, 32'h8);
    apb_rd_chk("thresh_rw", 32'h88, 32'd2);
    for (int i = 0; i < 3; i++) ocp_xfer(3'd1, 32'h0C, 32'(i), 4'h1, rsp, sd);
    check("irq_before", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_assert", 32'(irq), 32'd1);
    apb_xfer(1'b0, 32'h0C, 32'd0, rd, cyc);
    check("irq_pop_data", rd, 32'd0);
    @(negedge clk);
    check("irq_deassert", 32'(irq), 32'd0);
`else
    apb_wr(32'h88, 32'd2);
    apb_wr(32'h8C, 32'h8);
    apb_rd_chk("thresh_off", 32'h88, 32'd0);
    apb_rd_chk("irq_en_off", 32'h8C, 32'd0);
    for (int i = 0; i < 3; i++) ocp_xfer(3'd1, 32'h0C, 32'(i), 4'h1, rsp, sd);
    @(negedge clk);
    check("irq_off", 32'(irq), 32'd0);
`endif

    // randomized traffic, checked every cycle by the model
    phase = 0;
    wait_cnt = 0;
    for (int k = 0; k < 3010; k++) begin
      ocp_mcmd = 3'd0;
      if (k < 3000) begin
        r = $urandom_range(0, 9);
        if (r < ((k < 1500) ? 2 : 6)) begin
          ocp_mcmd = 3'd1;
          ocp_maddr = 32'($urandom_range(0, NCHAN - 1)) * 4 + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
          ocp_mdata = $urandom;
          ocp_mbyteen = ($urandom_range(0, 7) == 0) ? 4'he : 4'(($urandom) | 1);
        end else if (r == 6) begin
          ocp_mcmd = 3'd2;
          ocp_maddr = 32'h80;
        end else if (r == 7) begin
          ocp_mcmd = 3'($urandom_range(1, 7));
          case ($urandom_range(0, 3))
            0: ocp_maddr = 32'h10;
            1: ocp_maddr = 32'h84;
            2: ocp_maddr = 32'h8000_0000;
            default: ocp_maddr = $urandom;
          endcase
        end
      end

      if (phase == 2) begin
        wait_cnt++;
        if (apb_pready || wait_cnt > 8) begin
          if (!apb_pready) check("apb_timeout", 32'(apb_pready), 32'd1);
          apb_psel = 1'b0; apb_penable = 1'b0; phase = 0;
        end
      end else if (phase == 1) begin
        apb_penable = 1'b1; phase = 2; wait_cnt = 0;
      end else if (k < 3000 && $urandom_range(0, 1) == 1) begin
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_pwdata = $urandom;
        r = $urandom_range(0, 11);
        case (r)
          0, 1, 2, 3, 4: apb_paddr = 32'($urandom_range(0, NCHAN - 1)) * 4;
          5: apb_paddr = 32'h40 + 32'($urandom_range(0, NCHAN - 1)) * 4;
          6: apb_paddr = 32'h80 + 32'($urandom_range(0, 3)) * 4;
          7: begin apb_paddr = 32'h84; apb_pwrite = 1'b1; end
          8: begin apb_paddr = 32'h88; apb_pwrite = 1'b1; apb_pwdata = 32'($urandom_range(0, 20)); end
          9: begin apb_paddr = 32'h8C; apb_pwrite = 1'b1; end
          10: apb_paddr = ($urandom_range(0, 1) == 1) ? 32'h10 + 32'($urandom_range(0, 11)) * 4 : 32'h100;
          default: begin apb_paddr = 32'($urandom_range(0, 35)) * 4; apb_pwrite = 1'b1; end
        endcase
        apb_paddr = apb_paddr | 32'($urandom_range(0, 3));
        phase = 1;
      end
      @(negedge clk);
    end

    // reset in the middle of an OCP write aborts it and empties everything
    ocp_mcmd = 3'd1; ocp_maddr = 32'h04; ocp_mdata = 32'h77; ocp_mbyteen = 4'h1;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    ocp_mcmd = 3'd0;
    nrst = 1'b1;
    @(negedge clk);
    check("sresp_after_reset", 32'(ocp_sresp), 32'd0);
    apb_rd_chk("status_after_reset", 32'h80, 32'h0000_0000);
    apb_rd_chk("level_after_reset", 32'h44, 32'd0);
    apb_rd_chk("ovf_after_reset", 32'h84, 32'd0);
    apb_rd_chk("data_after_reset", 32'h04, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apbocp_mfifo.md
Name: apbocp_mfifo

Overview:
Multi-channel OCP-to-APB FIFO bridge and the parametrised successor of the single-channel OCP-to-APB FIFO.
- An OCP master pushes bytes into one of NCHAN independent FIFOs, selected by address.
- An APB master pops data, reads per-channel fill levels and manages sticky overflow flags.
- Sits between a CPU-side OCP port and a peripheral-side APB bus, e.g. for console or mailbox traffic.

Parameters:
NCHAN, 4, number of channels; power of 2, range 1..16
FIFO_DEPTH, 256, entries per channel; power of 2, range 2..4096
FIFO_DATA_WIDTH, 8, bits per entry; must be <= DATA_WIDTH-2
DATA_WIDTH, 32, APB/OCP data width; fixed at 32
APB_ADDR_WIDTH, 32, APB address width
OCP_ADDR_WIDTH, 32, OCP address width

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
apb_paddr  in  APB_ADDR_WIDTH  APB address
apb_psel  in  1  APB select
apb_penable  in  1  APB enable
apb_pwrite  in  1  APB write
apb_pwdata  in  DATA_WIDTH  APB write data
apb_prdata  out  DATA_WIDTH  APB read data, registered
apb_pready  out  1  APB ready, registered
ocp_maddr  in  OCP_ADDR_WIDTH  OCP address
ocp_mcmd  in  3  OCP command: 0 idle, 1 write, 2 read
ocp_mdata  in  DATA_WIDTH  OCP write data
ocp_mbyteen  in  DATA_WIDTH/8  OCP byte enables
ocp_scmdaccept  out  1  tied to 1
ocp_sdata  out  DATA_WIDTH  OCP read data, registered
ocp_sresp  out  2  OCP response: 0 NULL, 1 DVA, 2 FAIL, 3 ERR
irq  out  1  level interrupt; see Optional Feature

Behaviour:
- Reset (nrst low, async): all pointers 0, all FIFOs empty, OVF flags 0, THRESH 0, IRQ_EN 0. Outputs at reset: apb_prdata 0, apb_pready 0, ocp_sdata 0, ocp_sresp NULL, irq 0.
- Pointers: per channel, log2(FIFO_DEPTH)+1 bits each (extra wrap bit). level = wr-rd. empty = (level==0); full = (level==FIFO_DEPTH).
- APB FSM states:
  - IDLE: on psel&penable, perform the access and latch prdata; go to RESP.
  - RESP: pready=1 for exactly one cycle; go to IDLE.
  - pready is 0 in all other cycles, so each access has exactly one wait state.
- APB map (byte offsets, paddr[1:0] ignored, bits above 7 must be 0):
  - 0x00+4*ch, DATA, RO: not empty -> {0, full, 0.., entry}, pop. Empty -> {1, full, 0..}, no pop.
  - 0x40+4*ch, LEVEL, RO: zero-extended level.
  - 0x80, STATUS, RO: [15:0] not-empty per channel; [31:16] full per channel.
  - 0x84, OVF, W1C: sticky overflow per channel, bits [NCHAN-1:0].
  - 0x88, THRESH, RW: bits [12:0].
  - 0x8C, IRQ_EN, RW: bits [NCHAN-1:0].
  - Channel index >= NCHAN or any other offset: reads 0xFFFFFFFF, writes ignored; no error signalling on APB.
- OCP: response is registered; sresp/sdata valid exactly one cycle after mcmd != idle, then NULL/0.
  - Write, maddr in 0x00..4*NCHAN-4, ch = maddr[2+:log2 NCHAN]:
    - mbyteen[0]=1 and not full: push mdata[FIFO_DATA_WIDTH-1:0]; resp DVA.
    - Full: drop data, set OVF[ch]; resp FAIL.
    - mbyteen[0]=0: no push; resp DVA.
  - Read at 0x80: sdata = STATUS; resp DVA.
  - Any other address or command: resp ERR, sdata 0.
- Simultaneous push and pop on the same channel: both evaluated on pre-cycle state.
  - Push to a full FIFO fails even if a pop occurs in the same cycle.
  - Pop from an empty FIFO returns empty even if a push occurs in the same cycle.
  - Push and pop both succeed when neither condition applies; level unchanged.
- OVF: a set from OCP and a W1C clear in the same cycle on the same bit -> set wins.
- Wrap-around: pointers roll modulo 2*FIFO_DEPTH; no level discontinuity at the wrap.
- Reset mid-transfer aborts the APB/OCP transaction; FIFO contents are lost.

Optional Feature:
APBOCP_MFIFO_IRQ_EN
- Defined: irq = OR over ch of IRQ_EN[ch] & (OVF[ch] | (level[ch] > THRESH)). Registered, so one cycle of latency.
- Undefined: irq tied 0. THRESH and IRQ_EN read 0 and writes to them are ignored. OVF remains functional.

Test Plan:
- Reset, then APB read 0x80 -> 0x00000000; read 0x00 -> 0x80000000; ocp_sresp NULL.
- OCP write 0x41 to 0x04, then APB read 0x04 -> 0x00000041 after one wait state; LEVEL ch1 (0x44) 1 -> 0.
- Fill ch0 with FIFO_DEPTH writes; the next write -> FAIL. STATUS bit16=1; OVF=0x1; write 0x1 to 0x84 -> OVF=0.
- Same-cycle OCP push to ch2 and APB pop of ch2 at level 3 -> both succeed, level stays 3, data order preserved across pointer wrap.
- OCP write to 0x40 -> ERR; APB read 0x90 -> 0xFFFFFFFF; OCP read 0x80 -> DVA with STATUS value.
- With APBOCP_MFIFO_IRQ_EN: THRESH=2, IRQ_EN=0x8, 3 pushes to ch3 -> irq=1 one cycle after the 3rd response; one pop -> irq=0.
